// File: rtl/ibex_fetch_align_buffer.sv
// Word-aligned fetch buffer that presents one realigned instruction (compressed or 32-bit,
// possibly straddling two words) per handshake, together with its PC.
module ibex_fetch_align_buffer #(
   parameter int unsigned Depth = 3
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clear_i,
   input  logic [31:0] clear_addr_i,
   input  logic        in_valid_i,
   input  logic [31:0] in_rdata_i,
   input  logic        in_err_i,
   output logic        busy_o,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] out_rdata_o,
   output logic [31:0] out_addr_o,
   output logic        out_err_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } entry_t;

   entry_t          mem_q [Depth];
   logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
   logic [CntW-1:0] count_q;
   logic [31:0]     addr_q;

   entry_t      head, nxt;
   logic        off, compressed, not_empty, has_two;
   logic [15:0] lo;
   logic        valid, accept, push, pop;
   logic [31:0] rdata_c;
   logic        err_c;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   assign head       = mem_q[rd_ptr_q];
   assign nxt        = mem_q[ptr_inc(rd_ptr_q)];
   assign off        = addr_q[1];
   assign lo         = off ? head.rdata[31:16] : head.rdata[15:0];
   assign compressed = (lo[1:0] != 2'b11);
   assign not_empty  = (count_q != '0);
   assign has_two    = (count_q >= CntW'(2));

   // An unaligned 32-bit instruction needs the next word before it can be presented.
   assign valid  = not_empty & (head.err | compressed | ~off | has_two);
   assign accept = valid & out_ready_i;
   assign pop    = accept & (off | ~compressed);
   assign push   = in_valid_i & ((count_q != CntW'(Depth)) | pop);

   always_comb begin
      rdata_c = '0;
      err_c   = 1'b0;
      if (valid) begin
         if (compressed)  rdata_c = {16'h0, lo};
         else if (!off)   rdata_c = head.rdata;
         else             rdata_c = {nxt.rdata[15:0], head.rdata[31:16]};
         err_c = head.err | (~compressed & off & has_two & nxt.err);
      end
   end

   assign out_valid_o = valid;
   assign out_rdata_o = rdata_c;
   assign out_err_o   = err_c;
   assign out_addr_o  = addr_q;
   assign busy_o      = (count_q >= CntW'(Depth - 1));

   // NOTE: storage has no reset; occupancy gates every read, so stale contents are never visible.
   always_ff @(posedge clk_i) begin
      if (push && !clear_i) mem_q[wr_ptr_q] <= '{rdata: in_rdata_i, err: in_err_i};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         addr_q   <= '0;
      end else if (clear_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         addr_q   <= {clear_addr_i[31:1], 1'b0};
      end else begin
         if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         case ({push, pop})
            2'b10:   count_q <= count_q + CntW'(1);
            2'b01:   count_q <= count_q - CntW'(1);
            default: count_q <= count_q;
         endcase
         if (accept) addr_q <= addr_q + (compressed ? 32'd2 : 32'd4);
      end
   end

   // A response arriving while full with no pop would be lost.
   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (in_valid_i && !clear_i && count_q == CntW'(Depth)) |-> pop);

   a_stable_out: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (out_valid_o && !out_ready_i && !clear_i) |=>
         ($stable(out_rdata_o) && $stable(out_addr_o) && $stable(out_err_o)));

endmodule

// File: tb/tb_ibex_fetch_align_buffer.sv
// Directed, table-driven bench for ibex_fetch_align_buffer (Depth = 3).
module tb_ibex_fetch_align_buffer;

   logic        clk_i, rst_ni;
   logic        clear_i;
   logic [31:0] clear_addr_i;
   logic        in_valid_i;
   logic [31:0] in_rdata_i;
   logic        in_err_i;
   logic        busy_o, out_valid_o, out_ready_i, out_err_o;
   logic [31:0] out_rdata_o, out_addr_o;

   int n_tests = 0;
   int n_fail  = 0;

   ibex_fetch_align_buffer #(.Depth(3)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .clear_i      (clear_i),
      .clear_addr_i (clear_addr_i),
      .in_valid_i   (in_valid_i),
      .in_rdata_i   (in_rdata_i),
      .in_err_i     (in_err_i),
      .busy_o       (busy_o),
      .out_valid_o  (out_valid_o),
      .out_ready_i  (out_ready_i),
      .out_rdata_o  (out_rdata_o),
      .out_addr_o   (out_addr_o),
      .out_err_o    (out_err_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   // One row = inputs driven during a cycle plus the outputs expected in that same cycle.
   typedef struct {
      logic        clr;
      logic [31:0] clr_addr;
      logic        in_v;
      logic [31:0] in_d;
      logic        in_e;
      logic        rdy;
      logic        e_valid;
      logic [31:0] e_rdata;
      logic [31:0] e_addr;
      logic        e_err;
      logic        e_busy;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic clr, input logic [31:0] clr_addr, input logic in_v,
                      input logic [31:0] in_d, input logic in_e, input logic rdy,
                      input logic e_valid, input logic [31:0] e_rdata, input logic [31:0] e_addr,
                      input logic e_err, input logic e_busy);
      vec_t v;
      v.clr = clr; v.clr_addr = clr_addr; v.in_v = in_v; v.in_d = in_d; v.in_e = in_e;
      v.rdy = rdy; v.e_valid = e_valid; v.e_rdata = e_rdata; v.e_addr = e_addr;
      v.e_err = e_err; v.e_busy = e_busy;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic clr, input logic [31:0] clr_addr, input logic in_v,
                        input logic [31:0] in_d, input logic in_e, input logic rdy);
      clear_i = clr; clear_addr_i = clr_addr; in_valid_i = in_v;
      in_rdata_i = in_d; in_err_i = in_e; out_ready_i = rdy;
   endtask

   initial begin
      rst_ni = 1'b0;
      drive(0, 0, 0, 0, 0, 0);

      // clear/addr   push/data/err    rdy  valid  rdata   addr  err busy
      // 1: aligned 32-bit
      add(1, 32'h100, 0, 0, 0, 0,               0, 0, 32'h0, 0, 0);
      add(0, 0, 1, 32'h00A00093, 0, 0,          0, 0, 32'h100, 0, 0);
      add(0, 0, 0, 0, 0, 1,                     1, 32'h00A00093, 32'h100, 0, 0);
      // 2: two compressed in one word
      add(1, 32'h100, 0, 0, 0, 0,               0, 0, 32'h104, 0, 0);
      add(0, 0, 1, 32'h45014505, 0, 0,          0, 0, 32'h100, 0, 0);
      add(0, 0, 0, 0, 0, 1,                     1, 32'h4505, 32'h100, 0, 0);
      add(0, 0, 0, 0, 0, 1,                     1, 32'h4501, 32'h102, 0, 0);
      add(0, 0, 0, 0, 0, 0,                     0, 0, 32'h104, 0, 0);
      // 3: straddling 32-bit, bit 0 of clear address ignored
      add(1, 32'h103, 0, 0, 0, 0,               0, 0, 32'h104, 0, 0);
      add(0, 0, 1, 32'h00931234, 0, 0,          0, 0, 32'h102, 0, 0);
      add(0, 0, 1, 32'h567800A0, 0, 0,          0, 0, 32'h102, 0, 0);
      add(0, 0, 0, 0, 0, 1,                     1, 32'h00A00093, 32'h102, 0, 1);
      add(0, 0, 0, 0, 0, 0,                     1, 32'h5678, 32'h106, 0, 0);
      add(0, 0, 0, 0, 0, 1,                     1, 32'h5678, 32'h106, 0, 0);
      add(0, 0, 0, 0, 0, 0,                     0, 0, 32'h108, 0, 0);
      // 4: fill, backpressure, push+pop at full
      add(1, 32'h200, 0, 0, 0, 0,               0, 0, 32'h108, 0, 0);
      add(0, 0, 1, 32'h00000013, 0, 0,          0, 0, 32'h200, 0, 0);
      add(0, 0, 1, 32'h00100093, 0, 0,          1, 32'h00000013, 32'h200, 0, 0);
      add(0, 0, 1, 32'h00200113, 0, 0,          1, 32'h00000013, 32'h200, 0, 1);
      for (int i = 0; i < 5; i++)
         add(0, 0, 0, 0, 0, 0,                  1, 32'h00000013, 32'h200, 0, 1);
      add(0, 0, 1, 32'h00300193, 0, 1,          1, 32'h00000013, 32'h200, 0, 1);
      add(0, 0, 0, 0, 0, 0,                     1, 32'h00100093, 32'h204, 0, 1);
      add(0, 0, 0, 0, 0, 1,                     1, 32'h00100093, 32'h204, 0, 1);
      add(0, 0, 0, 0, 0, 1,                     1, 32'h00200113, 32'h208, 0, 1);
      add(0, 0, 0, 0, 0, 1,                     1, 32'h00300193, 32'h20C, 0, 0);
      add(0, 0, 0, 0, 0, 0,                     0, 0, 32'h210, 0, 0);
      // 5: error word, then straddle whose second word has err
      add(1, 32'h300, 0, 0, 0, 0,               0, 0, 32'h210, 0, 0);
      add(0, 0, 1, 32'hDEAD0013, 1, 0,          0, 0, 32'h300, 0, 0);
      add(0, 0, 0, 0, 0, 1,                     1, 32'hDEAD0013, 32'h300, 1, 0);
      add(1, 32'h302, 0, 0, 0, 0,               0, 0, 32'h304, 0, 0);
      add(0, 0, 1, 32'h00930000, 0, 0,          0, 0, 32'h302, 0, 0);
      add(0, 0, 1, 32'h000000A0, 1, 0,          0, 0, 32'h302, 0, 0);
      add(0, 0, 0, 0, 0, 1,                     1, 32'h00A00093, 32'h302, 1, 1);
      add(0, 0, 0, 0, 0, 1,                     1, 32'h00000000, 32'h306, 1, 0);
      add(0, 0, 0, 0, 0, 0,                     0, 0, 32'h308, 0, 0);
      // 6: clear with push and accept in the same cycle
      add(0, 0, 1, 32'h00000013, 0, 0,          0, 0, 32'h308, 0, 0);
      add(1, 32'h400, 1, 32'h11111111, 0, 1,    1, 32'h00000013, 32'h308, 0, 0);
      add(0, 0, 0, 0, 0, 0,                     0, 0, 32'h400, 0, 0);
      // PC wrap-around
      add(1, 32'hFFFFFFFE, 0, 0, 0, 0,          0, 0, 32'h400, 0, 0);
      add(0, 0, 1, 32'h45014505, 0, 0,          0, 0, 32'hFFFFFFFE, 0, 0);
      add(0, 0, 0, 0, 0, 1,                     1, 32'h4501, 32'hFFFFFFFE, 0, 0);
      add(0, 0, 0, 0, 0, 0,                     0, 0, 32'h0, 0, 0);

      // Reset state
      repeat (2) @(negedge clk_i);
      #1;
      check("reset valid", 32'(out_valid_o), 32'd0);
      check("reset rdata", out_rdata_o, 32'h0);
      check("reset addr",  out_addr_o, 32'h0);
      check("reset err",   32'(out_err_o), 32'd0);
      check("reset busy",  32'(busy_o), 32'd0);
      rst_ni = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk_i);
         drive(vecs[i].clr, vecs[i].clr_addr, vecs[i].in_v, vecs[i].in_d, vecs[i].in_e,
               vecs[i].rdy);
         #1;
         check($sformatf("row%0d valid", i), 32'(out_valid_o), 32'(vecs[i].e_valid));
         check($sformatf("row%0d addr", i), out_addr_o, vecs[i].e_addr);
         check($sformatf("row%0d busy", i), 32'(busy_o), 32'(vecs[i].e_busy));
         if (vecs[i].e_valid) begin
            check($sformatf("row%0d rdata", i), out_rdata_o, vecs[i].e_rdata);
            check($sformatf("row%0d err", i), 32'(out_err_o), 32'(vecs[i].e_err));
         end
      end

      // Asynchronous reset in the middle of a busy stream
      @(negedge clk_i); drive(1, 32'h500, 0, 0, 0, 0);
      @(negedge clk_i); drive(0, 0, 1, 32'h00A00093, 0, 0);
      @(negedge clk_i); drive(0, 0, 1, 32'h00100093, 0, 0);
      @(negedge clk_i); drive(0, 0, 0, 0, 0, 0);
      #1;
      check("pre-rst valid", 32'(out_valid_o), 32'd1);
      check("pre-rst addr",  out_addr_o, 32'h500);
      check("pre-rst busy",  32'(busy_o), 32'd1);
      #1 rst_ni = 1'b0;
      #1;
      check("mid-rst valid", 32'(out_valid_o), 32'd0);
      check("mid-rst rdata", out_rdata_o, 32'h0);
      check("mid-rst addr",  out_addr_o, 32'h0);
      check("mid-rst err",   32'(out_err_o), 32'd0);
      check("mid-rst busy",  32'(busy_o), 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
